// File: rtl/btn_conditioner.sv
// btn_conditioner
// Turns raw, bouncing, asynchronous push-button inputs into clean controls
// that are synchronous to clk. Each channel is synchronised, debounced and
// converted into a stable level plus single-cycle press and release pulses.
// Channels enabled in REPEAT_MASK also produce auto-repeat press pulses
// while the button stays held.
//
// Ports:
//   clk          single clock for all logic
//   rst          synchronous, active-high reset
//   btn_in       raw button levels, 1 = pressed (asynchronous)
//   btn_level    debounced level per channel
//   btn_press    1-cycle pulse on accepted press and on each auto-repeat
//   btn_release  1-cycle pulse on accepted release
module btn_conditioner #(
  parameter int               N_BTN           = 3,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_PERIOD   = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 3'b110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX + 1) : 1;

  // Counter values seen on the edge that completes a full count.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]       sync;
    state_t           state;
    logic [DEB_W-1:0] deb_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic             rep_phase;   // 0: waiting for first repeat, 1: periodic
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             repeating;
    logic             rep_hit;

    assign repeating = REPEAT_MASK[i] && ((state == HELD) || (state == RELEASE_WAIT));
    assign rep_hit   = repeating && (rep_cnt == (rep_phase ? PER_LAST : DLY_LAST));

    // NOTE: every register here uses non-blocking assignments so all channels
    // update from the same pre-edge values; the reset is sampled on the clock
    // edge like any other input, so no asynchronous paths exist.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync      <= 2'b00;
        state     <= IDLE;
        deb_cnt   <= '0;
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync      <= {sync[0], btn_in[i]};
        press_q   <= 1'b0;
        release_q <= 1'b0;

        // Repeat counter runs through RELEASE_WAIT so a short glitch during
        // a hold does not restart the repeat cadence.
        if (repeating) begin
          if (rep_hit) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end

        case (state)
          IDLE: begin
            if (sync[1]) begin
              if (DEBOUNCE_CYCLES == 1) begin
                state     <= HELD;
                level_q   <= 1'b1;
                press_q   <= 1'b1;
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
              end else begin
                state   <= PRESS_WAIT;
                deb_cnt <= DEB_W'(1);
              end
            end
          end

          PRESS_WAIT: begin
            if (!sync[1]) begin
              state   <= IDLE;
              deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
              state     <= HELD;
              deb_cnt   <= '0;
              level_q   <= 1'b1;
              press_q   <= 1'b1;
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end

          HELD: begin
            if (!sync[1] && (DEBOUNCE_CYCLES == 1)) begin
              // Release accepted immediately: the FSM enters IDLE, so no
              // repeat pulse may share this edge with btn_release.
              state     <= IDLE;
              level_q   <= 1'b0;
              release_q <= 1'b1;
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
            end else begin
              if (!sync[1]) begin
                state   <= RELEASE_WAIT;
                deb_cnt <= DEB_W'(1);
              end
              press_q <= rep_hit;
            end
          end

          RELEASE_WAIT: begin
            if (sync[1]) begin
              state   <= HELD;
              deb_cnt <= '0;
              press_q <= rep_hit;
            end else if (deb_cnt == DEB_LAST) begin
              state     <= IDLE;
              deb_cnt   <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
              press_q <= rep_hit;
            end
          end

          default: begin
            state   <= IDLE;
            deb_cnt <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule
